pixel_dispatch: RTL and testbench



---
 rtl/julia_pkg.sv | 6 +
 rtl/lowest_idle_pick.sv | 14 +
 rtl/pixel_dispatch.sv | 90 +++++++++
 tb/tb_pixel_dispatch.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// julia_pkg: shared types and constants for the Julia pixel pipeline
package julia_pkg;
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} dispatch_state_t;
  localparam int FRAC_BITS = 28;
  localparam logic [31:0] BYTES_PER_PIXEL = 32'd4;
endpackage

// File: rtl/lowest_idle_pick.sv
// lowest_idle_pick: one-hot grant of the lowest set bit of idle, valid when any bit set
//   idle  in  NUM_JULIA  candidate mask
//   grant out NUM_JULIA  one-hot lowest set bit (zero when idle is zero)
//   valid out 1          idle is nonzero
module lowest_idle_pick #(
  parameter int NUM_JULIA = 16
) (
  input  logic [NUM_JULIA-1:0] idle,
  output logic [NUM_JULIA-1:0] grant,
  output logic                 valid
);
  assign grant = idle & (~idle + NUM_JULIA'(1));
  assign valid = |idle;
endmodule

// File: rtl/pixel_dispatch.sv
// pixel_dispatch: issues frame pixels in raster order to the lowest-index idle Julia core
//   clk, rst            clock, synchronous active-high reset
//   start               frame start pulse, honoured only in IDLE
//   re_min/im_max/step  Q4.28 origin and per-pixel increment, latched on start
//   free                per-core pulse returning a core to idle
//   load                one-hot core strobe for pix_address/c_re/c_im
//   busy/frame_done     not-IDLE level / end-of-frame pulse
//   protocol_err        sticky: free seen for a core already idle
module pixel_dispatch
  import julia_pkg::*;
#(
  parameter int          NUM_JULIA = 16,
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter logic [31:0] FB_BASE   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          re_min,
  input  logic [31:0]          im_max,
  input  logic [31:0]          step,
  input  logic [NUM_JULIA-1:0] free,
  output logic [NUM_JULIA-1:0] load,
  output logic [31:0]          pix_address,
  output logic [31:0]          c_re,
  output logic [31:0]          c_im,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 protocol_err
);
  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);
  dispatch_state_t state;
  logic [NUM_JULIA-1:0] idle, grant;
  logic valid, last_col, last_row;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [31:0] re_org, step_r;
  lowest_idle_pick #(.NUM_JULIA(NUM_JULIA)) u_pick (
    .idle (idle),
    .grant(grant),
    .valid(valid)
  );
  // load is gated by rst so nothing is strobed in the cycle reset is applied
  assign load       = (state == DISPATCH && !rst) ? grant : '0;
  assign busy       = state != IDLE;
  assign frame_done = state == DONE;
  assign last_col   = x == XW'(H_RES - 1);
  assign last_row   = y == YW'(V_RES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idle         <= '1;
      x            <= '0;
      y            <= '0;
      pix_address  <= FB_BASE;
      c_re         <= '0;
      c_im         <= '0;
      re_org       <= '0;
      step_r       <= '0;
      protocol_err <= 1'b0;
    end else begin
      idle <= (idle | free) & ~load;
      if (|(free & idle)) protocol_err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          re_org      <= re_min;
          step_r      <= step;
          x           <= '0;
          y           <= '0;
          pix_address <= FB_BASE;
          c_re        <= re_min;
          c_im        <= im_max;
          state       <= DISPATCH;
        end
        DISPATCH: if (valid) begin
          pix_address <= pix_address + BYTES_PER_PIXEL;
          x           <= last_col ? '0 : x + XW'(1);
          y           <= last_col ? y + YW'(1) : y;
          c_re        <= last_col ? re_org : c_re + step_r;
          c_im        <= last_col ? c_im - step_r : c_im;
          if (last_col && last_row) state <= DRAIN;
        end
        DRAIN: if (&idle) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_dispatch.sv
// tb_pixel_dispatch: scoreboard bench for pixel_dispatch (4 cores, 4x2 frame)
module tb_pixel_dispatch;
  import julia_pkg::*;
  localparam logic [31:0] ONE    = 32'd1 << FRAC_BITS;
  localparam logic [31:0] RE_MIN = -(ONE * 2);
  localparam logic [31:0] IM_MAX = ONE;
  localparam logic [31:0] STEP   = ONE >> 1;
  typedef struct {
    logic [3:0]  ld;
    logic [31:0] a;
    logic [31:0] re;
    logic [31:0] im;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] re_min = RE_MIN, im_max = IM_MAX, step = STEP;
  logic [3:0] free = '0, load;
  logic [31:0] pix_address, c_re, c_im;
  logic busy, frame_done, protocol_err;
  exp_t sb[$];
  logic [3:0] hist[$];
  int n_checks = 0, n_fail = 0, n_loads = 0;
  logic [31:0] last_addr;
  logic mon_en = 1'b0;
  pixel_dispatch #(.NUM_JULIA(4), .H_RES(4), .V_RES(2), .FB_BASE(32'h1000)) dut (
    .clk(clk), .rst(rst), .start(start), .re_min(re_min), .im_max(im_max), .step(step),
    .free(free), .load(load), .pix_address(pix_address), .c_re(c_re), .c_im(c_im),
    .busy(busy), .frame_done(frame_done), .protocol_err(protocol_err)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  always @(negedge clk) if (mon_en && load !== 4'b0000) begin
    exp_t e;
    n_checks++;
    n_loads++;
    last_addr = pix_address;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_load: load=%b addr=%h with no pixel expected", load, pix_address);
    end else begin
      e = sb.pop_front();
      if (load !== e.ld || pix_address !== e.a || c_re !== e.re || c_im !== e.im) begin
        n_fail++;
        $display("FAIL dispatch: got load=%b addr=%h re=%h im=%h, want load=%b addr=%h re=%h im=%h",
                 load, pix_address, c_re, c_im, e.ld, e.a, e.re, e.im);
      end
    end
  end
  function automatic void push(int p, logic [3:0] ld);
    int x = p % 4, y = p / 4;
    sb.push_back('{ld, 32'h1000 + 32'(p * 4), RE_MIN + 32'(x) * STEP, IM_MAX - 32'(y) * STEP});
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    free = '0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask
  task automatic expect_drained(string name);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected loads never appeared, want 0", name, sb.size());
    end
  endtask
  task automatic test_reset;
    do_reset();
    mon_en = 1'b1;
    n_checks += 7;
    if (load !== 4'b0) begin n_fail++; $display("FAIL reset_load: got %b want 0000", load); end
    if (pix_address !== 32'h1000) begin n_fail++; $display("FAIL reset_addr: got %h want 00001000", pix_address); end
    if (c_re !== 32'h0) begin n_fail++; $display("FAIL reset_c_re: got %h want 0", c_re); end
    if (c_im !== 32'h0) begin n_fail++; $display("FAIL reset_c_im: got %h want 0", c_im); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", frame_done); end
    if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", protocol_err); end
  endtask
  task automatic test_burst;
    for (int i = 0; i < 4; i++) push(i, 4'(1 << i));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    expect_drained("burst");
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL burst_busy: got %b want 1", busy); end
    if (load !== 4'b0) begin n_fail++; $display("FAIL burst_stall: got load %b want 0000", load); end
  endtask
  task automatic test_free_reload;
    push(4, 4'b0100);
    free = 4'b0100;
    tick();
    free = '0;
    repeat (2) tick();
    expect_drained("free_reload");
  endtask
  task automatic test_full_frame;
    int done_cnt = 0, done_at = -1, last_free = -1;
    do_reset();
    hist.delete();
    for (int i = 0; i < 8; i++) push(i, 4'(1 << (i % 4)));
    n_loads = 0;
    start = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tick();
      start = 1'b0;
      free = hist.size() >= 3 ? hist[hist.size() - 3] : 4'b0;
      if (free != 0) last_free = t;
      hist.push_back(load);
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_at = t;
      end
    end
    free = '0;
    expect_drained("frame");
    n_checks += 5;
    if (n_loads != 8) begin n_fail++; $display("FAIL frame_loads: got %0d want 8", n_loads); end
    if (last_addr !== 32'h101C) begin n_fail++; $display("FAIL frame_last_addr: got %h want 0000101c", last_addr); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d want 1", done_cnt); end
    if (done_at - last_free != 2) begin n_fail++; $display("FAIL frame_done_timing: got %0d cycles after last free, want 2", done_at - last_free); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_after: got %b want 0", busy); end
  endtask
  task automatic test_free_load_same_cycle;
    do_reset();
    for (int i = 0; i < 4; i++) push(i, 4'(1 << i));
    start = 1'b1;
    tick();
    start = 1'b0;
    free = 4'b0001;
    tick();
    free = '0;
    repeat (5) tick();
    expect_drained("same_cycle");
    n_checks++;
    if (load !== 4'b0) begin n_fail++; $display("FAIL same_cycle_reload: got load %b want 0000", load); end
  endtask
  task automatic test_protocol_err;
    do_reset();
    for (int i = 0; i < 4; i++) push(i, 4'(1 << i));
    start = 1'b1;
    tick();
    start = 1'b0;
    free = 4'b0010;
    tick();
    free = '0;
    n_checks++;
    if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b want 1", protocol_err); end
    repeat (5) tick();
    expect_drained("perr_dispatch");
    n_checks++;
    if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b want 1", protocol_err); end
  endtask
  task automatic test_abort;
    do_reset();
    for (int i = 0; i < 3; i++) push(i, 4'(1 << i));
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (load !== 4'b0) begin n_fail++; $display("FAIL abort_rst_cycle_load: got %b want 0000", load); end
    tick();
    rst = 1'b0;
    expect_drained("abort_pre");
    n_checks += 4;
    if (load !== 4'b0) begin n_fail++; $display("FAIL abort_post_load: got %b want 0000", load); end
    if (pix_address !== 32'h1000) begin n_fail++; $display("FAIL abort_addr: got %h want 00001000", pix_address); end
    if (c_re !== 32'h0) begin n_fail++; $display("FAIL abort_c_re: got %h want 0", c_re); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    for (int i = 0; i < 4; i++) push(i, 4'(1 << i));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    expect_drained("abort_restart");
  endtask
  initial begin
    test_reset();
    test_burst();
    test_free_reload();
    test_full_frame();
    test_free_load_same_cycle();
    test_protocol_err();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
